alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk_i  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid_i  in  1  upstream op valid; in_ready_o  out  1  block can accept op.
REQ-004 SHALL have ports: aluop_i  in  3  main-control ALUOp; funct_i  in  6  R-type funct field.
REQ-005 SHALL have ports: src1_i, src2_i  in  32 each  operands.
REQ-006 SHALL have ports: alu_src1_o, alu_src2_o  out  32 each; alu_ctrl_o  out  4  drive to ALU.
REQ-007 SHALL have ports: alu_result_i  in  32; alu_zero_i  in  1  combinational ALU return.
REQ-008 SHALL have ports: out_valid_o  out  1; out_ready_i  in  1  downstream handshake.
REQ-009 SHALL have ports: result_o  out  32; zero_o, branch_taken_o, illegal_o  out  1 each.

Function
REQ-010 SHALL implement states IDLE, ISSUE, HOLD; in_ready_o = 1 only in IDLE.
REQ-011 IDLE: in_valid_i & in_ready_o at edge N SHALL latch operands and decoded ctrl into alu_src*/alu_ctrl_o, go ISSUE; else stay IDLE.
REQ-012 ISSUE: at edge N+1 SHALL capture alu_result_i/alu_zero_i into result_o/zero_o, set out_valid_o=1, go HOLD.
REQ-013 HOLD: out_valid_o and all outputs SHALL stay stable until out_valid_o & out_ready_i; at that edge out_valid_o=0, go IDLE.
REQ-014 Latency SHALL be: out_valid_o high after edge N+1; next accept no earlier than edge after completion handshake.
REQ-015 in_valid_i outside IDLE SHALL be ignored; operands not latched.
REQ-016 Decode SHALL be: aluop 000 -> 0010 (add); 001 -> 0110 (sub, beq); 011 -> 0010 (addi); 100 -> 0111 (slti).
REQ-017 aluop 010 SHALL decode funct: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111.
REQ-018 Any other aluop/funct SHALL set illegal_o=1, alu_ctrl_o=0000, and force result_o=0, zero_o=0, branch_taken_o=0.
REQ-019 branch_taken_o SHALL equal (aluop==001) & alu_zero_i, captured at the ISSUE edge.
REQ-020 illegal_o, branch_taken_o SHALL be registered with result_o and valid only while out_valid_o=1.
REQ-021 alu_src*/alu_ctrl_o SHALL hold their latched values through ISSUE and HOLD.

Reset
REQ-022 rst_i high at an edge SHALL override all activity, incl. in-flight op and pending handshake; state -> IDLE.
REQ-023 Reset values SHALL be: in_ready_o=1, out_valid_o=0, result_o=0, zero_o=0, branch_taken_o=0, illegal_o=0, alu_ctrl_o=0000, alu_src1_o=alu_src2_o=0.
REQ-024 An op presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-025 Macro ALU_ISSUE_BNE_EN defined: aluop 101 SHALL decode to 0110 and branch_taken_o = ~alu_zero_i.
REQ-026 Macro undefined: aluop 101 SHALL be illegal per REQ-018.

Verification
REQ-027 Reset: rst_i=1 one cycle -> in_ready_o=1, out_valid_o=0, all data outputs 0.
REQ-028 aluop=010, funct=101010, src1=0xFFFFFFFE, src2=0x00000001 -> alu_ctrl_o=0111, ALU model result 1 captured, out_valid_o high after edge N+1, result_o=1.
REQ-029 aluop=001, src1=src2=0x12345678 -> result_o=0, zero_o=1, branch_taken_o=1; src2=0x12345679 -> branch_taken_o=0.
REQ-030 Backpressure: out_ready_i=0 for 5 cycles -> out_valid_o and result_o stable, in_ready_o=0, new in_valid_i ignored; out_ready_i=1 -> IDLE next cycle.
REQ-031 aluop=010, funct=000000 -> illegal_o=1, result_o=0, branch_taken_o=0; aluop=101 -> illegal_o=1 without macro, branch on inequality with macro.
REQ-032 rst_i asserted during ISSUE and during HOLD -> no out_valid_o pulse, all outputs reset values next cycle.

Source files
------------

// File: rtl/alu_issue_if.sv
// Handshake and operand/result bundle between the issue stage, its ALU and the consumer.
// slave: the alu_issue block itself; master: whoever drives ops and consumes results.
interface alu_issue_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  aluop_i;
  logic [5:0]  funct_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [31:0] alu_result_i;
  logic        alu_zero_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        branch_taken_o;
  logic        illegal_o;

  modport slave (
    input  in_valid_i, aluop_i, funct_i, src1_i, src2_i,
    input  alu_result_i, alu_zero_i, out_ready_i,
    output in_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
    output out_valid_o, result_o, zero_o, branch_taken_o, illegal_o
  );

  modport master (
    output in_valid_i, aluop_i, funct_i, src1_i, src2_i,
    output alu_result_i, alu_zero_i, out_ready_i,
    input  in_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  out_valid_o, result_o, zero_o, branch_taken_o, illegal_o
  );
endinterface

// File: rtl/alu_issue.sv
// Single-op ALU issue stage: latch op, drive ALU for one cycle, hold result until consumed.
// Optional macro ALU_ISSUE_BNE_EN adds aluop 101 as branch-not-equal.
//
// state | meaning
// IDLE  | ready for a new op
// ISSUE | operands/ctrl driven to ALU, result captured at the next edge
// HOLD  | result presented, waiting for out_ready_i
module alu_issue (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_issue_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] src1_q, src1_d, src2_q, src2_d, result_q, result_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic        ill_pend_q, ill_pend_d, beq_q, beq_d, bne_q, bne_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic        zero_q, zero_d, bt_q, bt_d, illegal_q, illegal_d;

  logic [3:0]  dec_ctrl;
  logic        dec_ill, dec_beq, dec_bne;

  always_comb begin
    dec_ctrl = 4'b0000;
    dec_ill  = 1'b0;
    dec_beq  = (bus.aluop_i == 3'b001);
    dec_bne  = 1'b0;
    case (bus.aluop_i)
      3'b000: dec_ctrl = 4'b0010;
      3'b001: dec_ctrl = 4'b0110;
      3'b011: dec_ctrl = 4'b0010;
      3'b100: dec_ctrl = 4'b0111;
      3'b010: begin
        case (bus.funct_i)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0110;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b101010: dec_ctrl = 4'b0111;
          default:   dec_ill  = 1'b1;
        endcase
      end
`ifdef ALU_ISSUE_BNE_EN
      3'b101: begin
        dec_ctrl = 4'b0110;
        dec_bne  = 1'b1;
      end
`endif
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    ctrl_d      = ctrl_q;
    ill_pend_d  = ill_pend_q;
    beq_d       = beq_q;
    bne_d       = bne_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    bt_d        = bt_q;
    illegal_d   = illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          src1_d     = bus.src1_i;
          src2_d     = bus.src2_i;
          ctrl_d     = dec_ctrl;
          ill_pend_d = dec_ill;
          beq_d      = dec_beq;
          bne_d      = dec_bne;
          in_ready_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        out_valid_d = 1'b1;
        illegal_d   = ill_pend_q;
        // An illegal op still spends a cycle in ISSUE but its ALU return is discarded.
        if (ill_pend_q) begin
          result_d = 32'h0;
          zero_d   = 1'b0;
          bt_d     = 1'b0;
        end else begin
          result_d = bus.alu_result_i;
          zero_d   = bus.alu_zero_i;
          bt_d     = (beq_q & bus.alu_zero_i) | (bne_q & ~bus.alu_zero_i);
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready_i) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      src1_q      <= 32'h0;
      src2_q      <= 32'h0;
      ctrl_q      <= 4'b0000;
      ill_pend_q  <= 1'b0;
      beq_q       <= 1'b0;
      bne_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= 32'h0;
      zero_q      <= 1'b0;
      bt_q        <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      ctrl_q      <= ctrl_d;
      ill_pend_q  <= ill_pend_d;
      beq_q       <= beq_d;
      bne_q       <= bne_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      bt_q        <= bt_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready_o     = in_ready_q;
  assign bus.alu_src1_o     = src1_q;
  assign bus.alu_src2_o     = src2_q;
  assign bus.alu_ctrl_o     = ctrl_q;
  assign bus.out_valid_o    = out_valid_q;
  assign bus.result_o       = result_q;
  assign bus.zero_o         = zero_q;
  assign bus.branch_taken_o = bt_q;
  assign bus.illegal_o      = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus randomized ops against an op-level reference model.
module tb_alu_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if bus();
  alu_issue dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Combinational ALU sitting behind the issue stage.
  always_comb begin
    case (bus.alu_ctrl_o)
      4'b0010: bus.alu_result_i = bus.alu_src1_o + bus.alu_src2_o;
      4'b0110: bus.alu_result_i = bus.alu_src1_o - bus.alu_src2_o;
      4'b0000: bus.alu_result_i = bus.alu_src1_o & bus.alu_src2_o;
      4'b0001: bus.alu_result_i = bus.alu_src1_o | bus.alu_src2_o;
      4'b0111: bus.alu_result_i = {31'h0, $signed(bus.alu_src1_o) < $signed(bus.alu_src2_o)};
      default: bus.alu_result_i = 32'h0;
    endcase
    bus.alu_zero_i = (bus.alu_result_i == 32'h0);
  end

  typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ILL} kind_e;
  typedef struct packed {
    logic [3:0]  ctrl;
    logic        ill;
    logic [31:0] res;
    logic        zero;
    logic        bt;
  } exp_t;

  function automatic exp_t ref_model(input logic [2:0] a, input logic [5:0] f,
                                     input logic [31:0] x, input logic [31:0] y);
    exp_t  e;
    kind_e k;
    logic  is_beq, is_bne;
    k = K_ILL;
    is_beq = 1'b0;
    is_bne = 1'b0;
    if (a == 3'd0 || a == 3'd3) k = K_ADD;
    else if (a == 3'd1) begin k = K_SUB; is_beq = 1'b1; end
    else if (a == 3'd4) k = K_SLT;
    else if (a == 3'd2) begin
      if (f == 6'd32) k = K_ADD;
      else if (f == 6'd34) k = K_SUB;
      else if (f == 6'd36) k = K_AND;
      else if (f == 6'd37) k = K_OR;
      else if (f == 6'd42) k = K_SLT;
    end
`ifdef ALU_ISSUE_BNE_EN
    else if (a == 3'd5) begin k = K_SUB; is_bne = 1'b1; end
`endif
    e.ill = (k == K_ILL);
    case (k)
      K_ADD:   begin e.ctrl = 4'd2; e.res = x + y; end
      K_SUB:   begin e.ctrl = 4'd6; e.res = x - y; end
      K_AND:   begin e.ctrl = 4'd0; e.res = x & y; end
      K_OR:    begin e.ctrl = 4'd1; e.res = x | y; end
      K_SLT:   begin e.ctrl = 4'd7; e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; end
      default: begin e.ctrl = 4'd0; e.res = 32'd0; end
    endcase
    e.zero = !e.ill && (e.res == 32'd0);
    e.bt   = (is_beq && e.res == 32'd0) || (is_bne && e.res != 32'd0);
    return e;
  endfunction

  // Drivers only: called just after a negedge, return just after the next negedge.
  task automatic drive_op(input logic [2:0] a, input logic [5:0] f,
                          input logic [31:0] x, input logic [31:0] y);
    bus.in_valid_i = 1'b1;
    bus.aluop_i    = a;
    bus.funct_i    = f;
    bus.src1_i     = x;
    bus.src2_i     = y;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.src1_i     = $urandom;
    bus.src2_i     = $urandom;
  endtask

  task automatic handshake();
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_op(3'b000, 6'd0, 32'h11, 32'h22);
    rst = 1'b0;
    checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready_o); end
    checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
    checks++; if ({bus.result_o, bus.zero_o, bus.branch_taken_o, bus.illegal_o} !== 35'h0) begin
      errors++; $display("FAIL reset_data result=%h zero=%b bt=%b ill=%b exp all 0", bus.result_o, bus.zero_o, bus.branch_taken_o, bus.illegal_o); end
    checks++; if ({bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o} !== 68'h0) begin
      errors++; $display("FAIL reset_alu_drive ctrl=%h s1=%h s2=%h exp 0", bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o); end
    @(negedge clk);
    checks++; if (bus.in_ready_o !== 1'b1 || bus.alu_src1_o !== 32'h0) begin
      errors++; $display("FAIL reset_cycle_op_accepted in_ready=%b s1=%h exp 1/0", bus.in_ready_o, bus.alu_src1_o); end
  endtask

  task automatic test_slt();
    drive_op(3'b010, 6'b101010, 32'hFFFF_FFFE, 32'h0000_0001);
    checks++; if (bus.alu_ctrl_o !== 4'b0111) begin errors++; $display("FAIL slt_ctrl got=%b exp=0111", bus.alu_ctrl_o); end
    checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
      errors++; $display("FAIL slt_issue_phase valid=%b ready=%b exp 0/0", bus.out_valid_o, bus.in_ready_o); end
    @(negedge clk);
    checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL slt_latency valid=%b exp=1", bus.out_valid_o); end
    checks++; if (bus.result_o !== 32'd1) begin errors++; $display("FAIL slt_result got=%h exp=1", bus.result_o); end
    handshake();
    checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      errors++; $display("FAIL slt_complete valid=%b ready=%b exp 0/1", bus.out_valid_o, bus.in_ready_o); end
  endtask

  task automatic test_branch();
    logic [31:0] s2 [2];
    s2[0] = 32'h1234_5678;
    s2[1] = 32'h1234_5679;
    for (int i = 0; i < 2; i++) begin
      drive_op(3'b001, 6'd0, 32'h1234_5678, s2[i]);
      @(negedge clk);
      checks++; if (bus.branch_taken_o !== (i == 0)) begin
        errors++; $display("FAIL beq_taken case=%0d got=%b exp=%b", i, bus.branch_taken_o, i == 0); end
      checks++; if (bus.zero_o !== (i == 0) || (i == 0 && bus.result_o !== 32'h0)) begin
        errors++; $display("FAIL beq_zero case=%0d zero=%b result=%h", i, bus.zero_o, bus.result_o); end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] x, y, snap;
    x = $urandom;
    y = $urandom;
    drive_op(3'b000, 6'd0, x, y);
    @(negedge clk);
    snap = bus.result_o;
    checks++; if (snap !== x + y) begin errors++; $display("FAIL bp_result got=%h exp=%h", snap, x + y); end
    for (int c = 0; c < 5; c++) begin
      bus.in_valid_i = 1'b1;
      bus.aluop_i    = 3'b010;
      bus.funct_i    = 6'b100100;
      bus.src1_i     = $urandom;
      bus.src2_i     = $urandom;
      @(negedge clk);
      checks++; if (bus.out_valid_o !== 1'b1 || bus.result_o !== snap || bus.in_ready_o !== 1'b0 || bus.alu_src1_o !== x) begin
        errors++; $display("FAIL bp_stall cyc=%0d valid=%b result=%h ready=%b s1=%h exp 1/%h/0/%h", c, bus.out_valid_o, bus.result_o, bus.in_ready_o, bus.alu_src1_o, snap, x); end
    end
    bus.in_valid_i = 1'b0;
    handshake();
    checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1 || bus.alu_src1_o !== x) begin
      errors++; $display("FAIL bp_release valid=%b ready=%b s1=%h exp 0/1/%h", bus.out_valid_o, bus.in_ready_o, bus.alu_src1_o, x); end
  endtask

  task automatic test_illegal();
    logic [2:0]  a [3];
    logic [31:0] y [3];
    exp_t e;
    a[0] = 3'b010; a[1] = 3'b101; a[2] = 3'b101;
    y[0] = 32'h5;  y[1] = 32'h77; y[2] = 32'h78;
    for (int i = 0; i < 3; i++) begin
      e = ref_model(a[i], 6'b000000, 32'h77, y[i]);
      drive_op(a[i], 6'b000000, 32'h77, y[i]);
      checks++; if (bus.alu_ctrl_o !== e.ctrl) begin errors++; $display("FAIL ill_ctrl case=%0d got=%b exp=%b", i, bus.alu_ctrl_o, e.ctrl); end
      @(negedge clk);
      checks++; if ({bus.illegal_o, bus.result_o, bus.zero_o, bus.branch_taken_o} !== {e.ill, e.res, e.zero, e.bt}) begin
        errors++; $display("FAIL ill_out case=%0d ill=%b res=%h z=%b bt=%b exp %b/%h/%b/%b", i, bus.illegal_o, bus.result_o, bus.zero_o, bus.branch_taken_o, e.ill, e.res, e.zero, e.bt); end
      handshake();
    end
  endtask

  task automatic test_random();
    logic [5:0]  legal_f [5];
    logic [2:0]  a;
    logic [5:0]  f;
    logic [31:0] x, y;
    exp_t e;
    legal_f[0] = 6'd32; legal_f[1] = 6'd34; legal_f[2] = 6'd36; legal_f[3] = 6'd37; legal_f[4] = 6'd42;
    for (int n = 0; n < 40; n++) begin
      a = 3'($urandom_range(0, 7));
      f = ($urandom_range(0, 1) == 0) ? legal_f[$urandom_range(0, 4)] : 6'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if ($urandom_range(0, 3) == 0) x = {28'h0, 4'($urandom)};
      e = ref_model(a, f, x, y);
      drive_op(a, f, x, y);
      checks++; if (bus.alu_ctrl_o !== e.ctrl || bus.alu_src1_o !== x || bus.alu_src2_o !== y || bus.out_valid_o !== 1'b0) begin
        errors++; $display("FAIL rnd_issue n=%0d ctrl=%b s1=%h s2=%h v=%b exp %b/%h/%h/0", n, bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o, bus.out_valid_o, e.ctrl, x, y); end
      @(negedge clk);
      checks++; if ({bus.out_valid_o, bus.illegal_o, bus.result_o, bus.zero_o, bus.branch_taken_o} !== {1'b1, e.ill, e.res, e.zero, e.bt}) begin
        errors++; $display("FAIL rnd_result n=%0d a=%b f=%b v=%b ill=%b res=%h z=%b bt=%b exp 1/%b/%h/%b/%b", n, a, f, bus.out_valid_o, bus.illegal_o, bus.result_o, bus.zero_o, bus.branch_taken_o, e.ill, e.res, e.zero, e.bt); end
      for (int c = $urandom_range(0, 3); c > 0; c--) begin
        bus.in_valid_i = $urandom_range(0, 1);
        bus.src1_i = $urandom;
        @(negedge clk);
        checks++; if (bus.out_valid_o !== 1'b1 || bus.result_o !== e.res || bus.alu_src1_o !== x) begin
          errors++; $display("FAIL rnd_hold n=%0d v=%b res=%h s1=%h", n, bus.out_valid_o, bus.result_o, bus.alu_src1_o); end
      end
      bus.in_valid_i = 1'b0;
      handshake();
      checks++; if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
        errors++; $display("FAIL rnd_done n=%0d ready=%b v=%b exp 1/0", n, bus.in_ready_o, bus.out_valid_o); end
    end
  endtask

  task automatic test_reset_inflight();
    for (int phase = 0; phase < 2; phase++) begin
      drive_op(3'b000, 6'd0, 32'h0000_1000, 32'h0000_0234);
      if (phase == 1) begin
        @(negedge clk);
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL rst_hold_setup valid=%b exp=1", bus.out_valid_o); end
        bus.out_ready_i = 1'b1;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready_i = 1'b0;
      checks++; if ({bus.out_valid_o, bus.in_ready_o, bus.result_o, bus.zero_o, bus.branch_taken_o, bus.illegal_o} !== {2'b01, 35'h0}) begin
        errors++; $display("FAIL rst_inflight phase=%0d v=%b ready=%b res=%h z=%b bt=%b ill=%b", phase, bus.out_valid_o, bus.in_ready_o, bus.result_o, bus.zero_o, bus.branch_taken_o, bus.illegal_o); end
      checks++; if ({bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o} !== 68'h0) begin
        errors++; $display("FAIL rst_inflight_drive phase=%0d ctrl=%h s1=%h s2=%h", phase, bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o); end
      @(negedge clk);
      checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_no_pulse phase=%0d valid=%b", phase, bus.out_valid_o); end
    end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.aluop_i     = 3'b000;
    bus.funct_i     = 6'd0;
    bus.src1_i      = 32'h0;
    bus.src2_i      = 32'h0;
    @(negedge clk);
    test_reset();
    test_slt();
    test_branch();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
